// File: rtl/rename_stage.sv
// Register-rename stage: maps sources through the speculative RAT, allocates rd from the free pool,
// and keeps a retirement RAT that restores the speculative one on flush.
module rename_stage #(
    parameter int AREG_WIDTH = 5,
    parameter int PREG_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AREG_WIDTH-1:0] in_rs1,
    input  logic [AREG_WIDTH-1:0] in_rs2,
    input  logic [AREG_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wr,
    output logic                  fp_pop,
    input  logic [PREG_WIDTH-1:0] fp_data,
    input  logic                  fp_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PREG_WIDTH-1:0] out_prs1,
    output logic [PREG_WIDTH-1:0] out_prs2,
    output logic [PREG_WIDTH-1:0] out_prd,
    output logic [PREG_WIDTH-1:0] out_old_prd,
    output logic                  out_rd_wr,
    input  logic                  commit_valid,
    input  logic [AREG_WIDTH-1:0] commit_rd,
    input  logic [PREG_WIDTH-1:0] commit_prd,
    input  logic                  flush
);

    localparam int NUM_AREG = 1 << AREG_WIDTH;

    logic [PREG_WIDTH-1:0] rat_r       [NUM_AREG];
    logic [PREG_WIDTH-1:0] rrat_r      [NUM_AREG];
    logic [PREG_WIDTH-1:0] rrat_next_s [NUM_AREG];

    logic                  alloc_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  fp_pop_s;
    logic                  commit_en_s;

    logic                  out_valid_r;
    logic [PREG_WIDTH-1:0] out_prs1_r;
    logic [PREG_WIDTH-1:0] out_prs2_r;
    logic [PREG_WIDTH-1:0] out_prd_r;
    logic [PREG_WIDTH-1:0] out_old_prd_r;
    logic                  out_rd_wr_r;

    // Handshake: arch reg 0 never allocates, so only real allocations wait on the pool.
    always_comb begin
        alloc_s     = in_rd_wr & (in_rd != {AREG_WIDTH{1'b0}});
        in_ready_s  = ~flush & (~out_valid_r | out_ready) & ~(alloc_s & fp_empty);
        accept_s    = in_valid & in_ready_s;
        fp_pop_s    = accept_s & alloc_s;
        commit_en_s = commit_valid & (commit_rd != {AREG_WIDTH{1'b0}});
    end

    // Next retirement map, shared by the RRAT update and the flush restore.
    always_comb begin
        for (int i = 0; i < NUM_AREG; i++) begin
            if (commit_en_s && (commit_rd == AREG_WIDTH'(i))) begin
                rrat_next_s[i] = commit_prd;
            end else begin
                rrat_next_s[i] = rrat_r[i];
            end
        end
    end

    // Retirement RAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AREG; i++) rrat_r[i] <= PREG_WIDTH'(i);
        end else begin
            for (int i = 0; i < NUM_AREG; i++) rrat_r[i] <= rrat_next_s[i];
        end
    end

    // Speculative RAT: flush restore wins over a same-cycle allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AREG; i++) rat_r[i] <= PREG_WIDTH'(i);
        end else if (flush) begin
            for (int i = 0; i < NUM_AREG; i++) rat_r[i] <= rrat_next_s[i];
        end else if (fp_pop_s) begin
            rat_r[in_rd] <= fp_data;
        end
    end

    // Output register; sources read the RAT before this instruction's own rd update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_prs1_r    <= {PREG_WIDTH{1'b0}};
            out_prs2_r    <= {PREG_WIDTH{1'b0}};
            out_prd_r     <= {PREG_WIDTH{1'b0}};
            out_old_prd_r <= {PREG_WIDTH{1'b0}};
            out_rd_wr_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            out_prs1_r    <= rat_r[in_rs1];
            out_prs2_r    <= rat_r[in_rs2];
            out_prd_r     <= alloc_s ? fp_data : {PREG_WIDTH{1'b0}};
            out_old_prd_r <= alloc_s ? rat_r[in_rd] : {PREG_WIDTH{1'b0}};
            out_rd_wr_r   <= alloc_s;
        end else if (out_ready) begin
            out_valid_r   <= 1'b0;
        end
    end

    assign in_ready    = in_ready_s;
    assign fp_pop      = fp_pop_s;
    assign out_valid   = out_valid_r;
    assign out_prs1    = out_prs1_r;
    assign out_prs2    = out_prs2_r;
    assign out_prd     = out_prd_r;
    assign out_old_prd = out_old_prd_r;
    assign out_rd_wr   = out_rd_wr_r;

endmodule

// File: tb/tb_rename_stage.sv
// Directed, table-driven bench for rename_stage: each vector checks the combinational
// handshake before the edge and the registered outputs after it.
module tb_rename_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic [4:0] in_rd;
    logic       in_rd_wr;
    logic       fp_pop;
    logic [5:0] fp_data;
    logic       fp_empty;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_prs1;
    logic [5:0] out_prs2;
    logic [5:0] out_prd;
    logic [5:0] out_old_prd;
    logic       out_rd_wr;
    logic       commit_valid;
    logic [4:0] commit_rd;
    logic [5:0] commit_prd;
    logic       flush;

    int n_checks = 0;
    int n_pass   = 0;

    rename_stage #(.AREG_WIDTH(5), .PREG_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
        .fp_pop(fp_pop), .fp_data(fp_data), .fp_empty(fp_empty),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_old_prd(out_old_prd), .out_rd_wr(out_rd_wr),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_prd(commit_prd),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [4:0] rs1, rs2, rd;
        logic       wr;
        logic [5:0] fpd;
        logic       emp;
        logic       ordy;
        logic       cv;
        logic [4:0] crd;
        logic [5:0] cprd;
        logic       fl;
        logic       e_ready, e_pop, e_valid;
        logic [5:0] e_prs1, e_prs2, e_prd, e_old;
        logic       e_wr;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(
        input logic vld, input int rs1, input int rs2, input int rd, input logic wr,
        input int fpd, input logic emp, input logic ordy,
        input logic cv, input int crd, input int cprd, input logic fl,
        input logic e_ready, input logic e_pop, input logic e_valid,
        input int e_prs1, input int e_prs2, input int e_prd, input int e_old, input logic e_wr);
        vec_t v;
        v.vld = vld; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.wr = wr;
        v.fpd = 6'(fpd); v.emp = emp; v.ordy = ordy;
        v.cv = cv; v.crd = 5'(crd); v.cprd = 6'(cprd); v.fl = fl;
        v.e_ready = e_ready; v.e_pop = e_pop; v.e_valid = e_valid;
        v.e_prs1 = 6'(e_prs1); v.e_prs2 = 6'(e_prs2); v.e_prd = 6'(e_prd); v.e_old = 6'(e_old);
        v.e_wr = e_wr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input logic ev, input int p1, input int p2,
                            input int pd, input int po, input logic w);
        chk({tag, " out_valid"}, int'(out_valid), int'(ev));
        if (ev) begin
            chk({tag, " out_prs1"}, int'(out_prs1), p1);
            chk({tag, " out_prs2"}, int'(out_prs2), p2);
            chk({tag, " out_prd"}, int'(out_prd), pd);
            chk({tag, " out_old_prd"}, int'(out_old_prd), po);
            chk({tag, " out_rd_wr"}, int'(out_rd_wr), int'(w));
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.vld; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_rd_wr = v.wr;
        fp_data = v.fpd; fp_empty = v.emp; out_ready = v.ordy;
        commit_valid = v.cv; commit_rd = v.crd; commit_prd = v.cprd; flush = v.fl;
    endtask

    initial begin
        //                vld rs1 rs2 rd wr fpd emp ordy cv crd cprd fl | rdy pop val prs1 prs2 prd old wr
        vecs[0]  = mk(1, 1, 2, 3, 1, 63, 0, 1, 0, 0, 0, 0,   1, 1, 1,  1,  2, 63,  3, 1);
        vecs[1]  = mk(1, 3, 3, 5, 1, 62, 0, 1, 0, 0, 0, 0,   1, 1, 1, 63, 63, 62,  5, 1);
        vecs[2]  = mk(1, 5, 0, 0, 1,  7, 1, 1, 0, 0, 0, 0,   1, 0, 1, 62,  0,  0,  0, 0);
        vecs[3]  = mk(1, 5, 3, 6, 1, 10, 0, 0, 0, 0, 0, 0,   0, 0, 1, 62,  0,  0,  0, 0);
        vecs[4]  = mk(1, 5, 3, 6, 1, 10, 0, 0, 0, 0, 0, 0,   0, 0, 1, 62,  0,  0,  0, 0);
        vecs[5]  = mk(1, 5, 3, 6, 1, 10, 0, 0, 0, 0, 0, 0,   0, 0, 1, 62,  0,  0,  0, 0);
        vecs[6]  = mk(1, 5, 3, 6, 1, 10, 0, 1, 0, 0, 0, 0,   1, 1, 1, 62, 63, 10,  6, 1);
        vecs[7]  = mk(1, 6, 1, 7, 1, 11, 1, 1, 0, 0, 0, 0,   0, 0, 0,  0,  0,  0,  0, 0);
        vecs[8]  = mk(1, 6, 1, 7, 1, 11, 0, 1, 0, 0, 0, 0,   1, 1, 1, 10,  1, 11,  7, 1);
        vecs[9]  = mk(1, 7, 3, 9, 0, 12, 1, 1, 0, 0, 0, 0,   1, 0, 1, 11, 63,  0,  0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,   1, 0, 0,  0,  0,  0,  0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 3, 40, 0,  1, 0, 0,  0,  0,  0,  0, 0);
        vecs[12] = mk(1, 1, 1, 8, 1, 20, 0, 1, 0, 0, 0, 1,   0, 0, 0,  0,  0,  0,  0, 0);
        vecs[13] = mk(1, 3, 0, 4, 1, 21, 0, 1, 0, 0, 0, 0,   1, 1, 1, 40,  0, 21,  4, 1);
        vecs[14] = mk(1, 5, 6, 5, 0, 22, 0, 1, 0, 0, 0, 0,   1, 0, 1,  5,  6,  0,  0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 9, 33, 1,  0, 0, 0,  0,  0,  0,  0, 0);
        vecs[16] = mk(1, 9, 4, 1, 1, 50, 0, 1, 0, 0, 0, 0,   1, 1, 1, 33,  4, 50,  1, 1);
        vecs[17] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 55, 0,  1, 0, 0,  0,  0,  0,  0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1,   0, 0, 0,  0,  0,  0,  0, 0);
        vecs[19] = mk(1, 0, 3, 2, 0,  0, 0, 1, 0, 0, 0, 0,   1, 0, 1,  0, 40,  0,  0, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #12;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_prs1", int'(out_prs1), 0);
        chk("reset out_prs2", int'(out_prs2), 0);
        chk("reset out_prd", int'(out_prd), 0);
        chk("reset out_old_prd", int'(out_old_prd), 0);
        chk("reset out_rd_wr", int'(out_rd_wr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            string tag;
            @(negedge clk);
            drive(vecs[i]);
            tag = $sformatf("vec%0d", i);
            #1;
            chk({tag, " in_ready"}, int'(in_ready), int'(vecs[i].e_ready));
            chk({tag, " fp_pop"}, int'(fp_pop), int'(vecs[i].e_pop));
            @(posedge clk);
            #1;
            chk_outs(tag, vecs[i].e_valid, int'(vecs[i].e_prs1), int'(vecs[i].e_prs2),
                     int'(vecs[i].e_prd), int'(vecs[i].e_old), vecs[i].e_wr);
        end

        // Asynchronous reset mid-stream: out_valid is high from the last vector.
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        chk_outs("midrst", 1'b0, 0, 0, 0, 0, 1'b0);
        chk("midrst out_prs2", int'(out_prs2), 0);
        chk("midrst out_rd_wr", int'(out_rd_wr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(mk(1, 3, 4, 7, 1, 30, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("postrst fp_pop", int'(fp_pop), 1);
        @(posedge clk);
        #1;
        chk_outs("postrst", 1'b1, 3, 4, 30, 7, 1'b1);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("postrst drain out_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
